// File: rtl/ika2151_pkg.sv
// ---------------------------------------------------------------------------
// ika2151_pkg
// Shared definitions for the IKA2151 interval timer array.
//   timer_state_t   : per-channel FSM state encoding
//   MAX_TIMERS      : largest supported channel count
//   timer_params_ok : elaboration-time range check for the array parameters
// ---------------------------------------------------------------------------
package ika2151_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } timer_state_t;

  localparam int MAX_TIMERS = 8;

  function automatic bit timer_params_ok(input int num_timers,
                                         input int cnt_width,
                                         input int prescale_width);
    return (num_timers >= 1) && (num_timers <= MAX_TIMERS) &&
           (cnt_width >= 1) && (prescale_width >= 1);
  endfunction

endpackage

// File: rtl/ika2151_timer_ch.sv
// ---------------------------------------------------------------------------
// ika2151_timer_ch
// One interval-timer channel: run-edge detect, IDLE/LOAD/COUNT/DONE FSM,
// tick prescaler, up-counter with reload, overflow pulse and sticky flag.
// Ports:
//   i_EMUCLK        master clock, all state on rising edge
//   i_MRST          synchronous active-high reset
//   i_TICK          one-cycle timebase strobe
//   i_TEST_FASTCNT  every clock is a tick and the prescaler is bypassed
//   i_LOAD_VAL      reload value
//   i_PRESCALE      divider; p counts once per p+1 ticks
//   i_RUN           channel enable level
//   i_ONESHOT       stop in DONE after first overflow
//   i_IRQ_EN        overflow sets the flag
//   i_FLAG_RST      one-cycle flag clear
//   o_CNT           counter value
//   o_OVFL          one-cycle overflow pulse
//   o_FLAG          sticky overflow flag
// ---------------------------------------------------------------------------
module ika2151_timer_ch
  import ika2151_pkg::*;
#(
  parameter int CNT_WIDTH      = 10,
  parameter int PRESCALE_WIDTH = 4
) (
  input  logic                      i_EMUCLK,
  input  logic                      i_MRST,
  input  logic                      i_TICK,
  input  logic                      i_TEST_FASTCNT,
  input  logic [CNT_WIDTH-1:0]      i_LOAD_VAL,
  input  logic [PRESCALE_WIDTH-1:0] i_PRESCALE,
  input  logic                      i_RUN,
  input  logic                      i_ONESHOT,
  input  logic                      i_IRQ_EN,
  input  logic                      i_FLAG_RST,
  output logic [CNT_WIDTH-1:0]      o_CNT,
  output logic                      o_OVFL,
  output logic                      o_FLAG
);

  timer_state_t              state;
  logic [CNT_WIDTH-1:0]      cnt;
  logic [PRESCALE_WIDTH-1:0] pre;
  logic                      run_d;

  logic run_rise;
  logic pre_hit;
  logic step;
  logic wrap;

  // NOTE: every signal assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch.
  always_comb begin
    run_rise = i_RUN & ~run_d;
    pre_hit  = (pre == i_PRESCALE);
    step     = 1'b0;
    if (state == ST_COUNT && i_RUN) begin
      step = i_TEST_FASTCNT | (i_TICK & pre_hit);
    end
    wrap = step & (&cnt);
  end

  always_ff @(posedge i_EMUCLK) begin
    // NOTE: reset is synchronous and covers every state register; a reset
    // mid-count abandons the count and clears the run history so that a
    // held-high i_RUN is treated as a fresh rising edge.
    if (i_MRST) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      pre    <= '0;
      run_d  <= 1'b0;
      o_OVFL <= 1'b0;
      o_FLAG <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      run_d  <= i_RUN;
      o_OVFL <= wrap;

      // Set wins over a same-cycle clear.
      if (wrap && i_IRQ_EN) begin
        o_FLAG <= 1'b1;
      end else if (i_FLAG_RST) begin
        o_FLAG <= 1'b0;
      end

      unique case (state)
        ST_IDLE: begin
          if (run_rise) state <= ST_LOAD;
        end

        ST_LOAD: begin
          if (!i_RUN) begin
            state <= ST_IDLE;
          end else begin
            cnt   <= i_LOAD_VAL;
            pre   <= '0;
            state <= ST_COUNT;
          end
        end

        ST_COUNT: begin
          if (!i_RUN) begin
            // Pause: counter and prescaler keep their values.
            state <= ST_IDLE;
          end else if (i_TEST_FASTCNT) begin
            // Test mode steps every cycle; the prescaler is left untouched.
            cnt <= wrap ? i_LOAD_VAL : cnt + 1'b1;
            if (wrap && i_ONESHOT) state <= ST_DONE;
          end else if (i_TICK) begin
            if (pre_hit) begin
              pre <= '0;
              cnt <= wrap ? i_LOAD_VAL : cnt + 1'b1;
              if (wrap && i_ONESHOT) state <= ST_DONE;
            end else begin
              pre <= pre + 1'b1;
            end
          end
        end

        ST_DONE: begin
          if (!i_RUN) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_CNT = cnt;

endmodule

// File: rtl/ika2151_timer_array.sv
// ---------------------------------------------------------------------------
// ika2151_timer_array
// NUM_TIMERS independent interval timers sharing one timebase tick and one
// active-low interrupt line.
// Ports:
//   i_EMUCLK, i_MRST        clock and synchronous active-high reset
//   i_TICK, i_TEST_FASTCNT  timebase strobe and fast-count test mode
//   i_LOAD_VAL, i_PRESCALE  packed per-channel reload and divider fields
//   i_RUN, i_ONESHOT, i_IRQ_EN, i_FLAG_RST  per-channel control bits
//   o_CNT                   packed per-channel counter values
//   o_OVFL, o_FLAG          per-channel overflow pulse and sticky flag
//   o_IRQ_n                 low while any flag is set
// ---------------------------------------------------------------------------
module ika2151_timer_array
  import ika2151_pkg::*;
#(
  parameter int NUM_TIMERS     = 2,
  parameter int CNT_WIDTH      = 10,
  parameter int PRESCALE_WIDTH = 4
) (
  input  logic                               i_EMUCLK,
  input  logic                               i_MRST,
  input  logic                               i_TICK,
  input  logic                               i_TEST_FASTCNT,
  input  logic [NUM_TIMERS*CNT_WIDTH-1:0]    i_LOAD_VAL,
  input  logic [NUM_TIMERS*PRESCALE_WIDTH-1:0] i_PRESCALE,
  input  logic [NUM_TIMERS-1:0]              i_RUN,
  input  logic [NUM_TIMERS-1:0]              i_ONESHOT,
  input  logic [NUM_TIMERS-1:0]              i_IRQ_EN,
  input  logic [NUM_TIMERS-1:0]              i_FLAG_RST,
  output logic [NUM_TIMERS*CNT_WIDTH-1:0]    o_CNT,
  output logic [NUM_TIMERS-1:0]              o_OVFL,
  output logic [NUM_TIMERS-1:0]              o_FLAG,
  output logic                               o_IRQ_n
);

  if (!timer_params_ok(NUM_TIMERS, CNT_WIDTH, PRESCALE_WIDTH)) begin : g_bad_params
    $error("ika2151_timer_array: parameter out of range");
  end

  for (genvar k = 0; k < NUM_TIMERS; k++) begin : g_ch
    ika2151_timer_ch #(
      .CNT_WIDTH      (CNT_WIDTH),
      .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_ch (
      .i_EMUCLK       (i_EMUCLK),
      .i_MRST         (i_MRST),
      .i_TICK         (i_TICK),
      .i_TEST_FASTCNT (i_TEST_FASTCNT),
      .i_LOAD_VAL     (i_LOAD_VAL[k*CNT_WIDTH +: CNT_WIDTH]),
      .i_PRESCALE     (i_PRESCALE[k*PRESCALE_WIDTH +: PRESCALE_WIDTH]),
      .i_RUN          (i_RUN[k]),
      .i_ONESHOT      (i_ONESHOT[k]),
      .i_IRQ_EN       (i_IRQ_EN[k]),
      .i_FLAG_RST     (i_FLAG_RST[k]),
      .o_CNT          (o_CNT[k*CNT_WIDTH +: CNT_WIDTH]),
      .o_OVFL         (o_OVFL[k]),
      .o_FLAG         (o_FLAG[k])
    );
  end

  // Open-drain style: line pulled low by any set flag.
  assign o_IRQ_n = ~|o_FLAG;

endmodule

// File: doc/ika2151_timer_array.md
# ika2151_timer_array

Parametrised multi-channel interval timer generalising the OPM two-timer unit: N independent up-counters with per-channel prescaler, auto-reload or one-shot mode, sticky overflow flags and a shared open-drain-style IRQ. Sits beside the register file: control fields come from the register block, and the tick is the once-per-sample strobe from the timing generator. Intended for the IKA2151 successor and for sibling cores needing more timers.

## Interface
Parameters:
- NUM_TIMERS, 2, number of independent channels (1..8)
- CNT_WIDTH, 10, counter width per channel
- PRESCALE_WIDTH, 4, width of per-channel tick divider field

Ports:
- i_EMUCLK  in  1  emulator master clock; all state updates on rising edge
- i_MRST  in  1  reset, synchronous, active-high
- i_TICK  in  1  one-cycle timebase strobe (sample-rate tick)
- i_TEST_FASTCNT  in  1  test mode: every i_EMUCLK cycle acts as a prescaler-bypassing tick
- i_LOAD_VAL  in  NUM_TIMERS*CNT_WIDTH  per-channel reload value, channel k at [k*CNT_WIDTH +: CNT_WIDTH]
- i_PRESCALE  in  NUM_TIMERS*PRESCALE_WIDTH  per-channel divider; value p counts once per p+1 ticks
- i_RUN  in  NUM_TIMERS  level; 1 = channel enabled
- i_ONESHOT  in  NUM_TIMERS  1 = stop after first overflow; 0 = auto-reload
- i_IRQ_EN  in  NUM_TIMERS  1 = overflow sets the channel flag
- i_FLAG_RST  in  NUM_TIMERS  one-cycle pulse clears the channel flag
- o_CNT  out  NUM_TIMERS*CNT_WIDTH  current counter values
- o_OVFL  out  NUM_TIMERS  one-cycle overflow pulse (independent of IRQ_EN)
- o_FLAG  out  NUM_TIMERS  sticky flags
- o_IRQ_n  out  1  active-low interrupt, low while any flag set

## Operation
- Per-channel FSM states: IDLE, LOAD, COUNT, DONE.
- IDLE: counter and prescaler hold. Rising edge of i_RUN (registered previous value) -> LOAD.
- LOAD (one cycle): counter <= LOAD_VAL, prescaler <= 0, -> COUNT. i_RUN low during LOAD -> IDLE.
- COUNT: on effective tick, if prescaler == PRESCALE then prescaler <= 0 and counter steps; else prescaler += 1. Effective tick = i_TICK, or every cycle with prescaler ignored when i_TEST_FASTCNT = 1.
- Counter step: if counter == all-ones -> overflow: counter <= LOAD_VAL, o_OVFL pulses, flag set if IRQ_EN; ONESHOT=1 -> DONE. Otherwise counter += 1.
- Period = (2^CNT_WIDTH - LOAD_VAL) * (PRESCALE+1) ticks; LOAD_VAL = all-ones gives 1 count per overflow.
- DONE: counter holds LOAD_VAL, no further overflows; i_RUN low -> IDLE.
- i_RUN low in COUNT -> IDLE, counter keeps value (pause); re-raise reloads via LOAD.
- LOAD_VAL/PRESCALE changes mid-count take effect at next reload/compare only; no restart.
- Flag: set by overflow with IRQ_EN; cleared by FLAG_RST; simultaneous set and clear -> set wins. Clearing IRQ_EN does not clear a set flag.
- o_IRQ_n = NOR of all o_FLAG (combinational from flag registers).

## Timing
- Reset (i_MRST sampled high): all states IDLE, counters 0, prescalers 0, RUN history 0, o_OVFL 0, o_FLAG 0, o_IRQ_n 1. Reset mid-count abandons the count; a held-high i_RUN after reset is seen as a rising edge.
- i_RUN rise at cycle t -> LOAD at t+1 -> o_CNT = LOAD_VAL at t+2; ticks before t+2 ignored.
- Overflow-causing tick sampled at t -> o_OVFL, o_FLAG, o_CNT=LOAD_VAL visible at t+1; o_IRQ_n low at t+1.
- FLAG_RST at t -> flag low at t+1.
- Channels fully independent; simultaneous overflows on several channels each pulse at t+1.

## Structure
- Shared package ika2151_pkg: state enum (IDLE/LOAD/COUNT/DONE), parameter range checks.
- One sub-module ika2151_timer_ch (single channel: FSM, prescaler, counter, flag), instantiated NUM_TIMERS times by generate; top holds field slicing and IRQ NOR.

## Test plan
- Defaults, ch0 LOAD=1020, PRESCALE=0, RUN=1, IRQ_EN=1, i_TICK every 4 cycles -> o_CNT 1020,1021,1022,1023, 4th tick gives o_OVFL pulse, o_CNT=1020, FLAG0=1, o_IRQ_n=0; repeats every 4 ticks.
- Ch1 LOAD=1022, PRESCALE=2, ONESHOT=1 -> overflow after 6 ticks, single o_OVFL, state DONE, no second pulse after 20 more ticks; drop and raise RUN -> counts again.
- IRQ_EN=0, overflow -> o_OVFL pulses, FLAG stays 0, o_IRQ_n stays 1.
- FLAG_RST asserted on same cycle as overflow -> flag 1; FLAG_RST next cycle alone -> flag 0, o_IRQ_n 1.
- RUN dropped at count 1021, 10 ticks, RUN raised -> count held at 1021, then reloads to LOAD_VAL.
- i_MRST mid-count with RUN held high -> all outputs reset values, then LOAD and count resumes from LOAD_VAL; i_TEST_FASTCNT=1 with LOAD=1020, PRESCALE=5 -> overflow 4 cycles after COUNT entry.
